// File: rtl/keypad_number_entry_pkg.sv
// Shared constants, types and helper functions for the keypad number entry block.
package keypad_number_entry_pkg;

  localparam logic [3:0]  KEY_ENTER = 4'hA;
  localparam logic [3:0]  KEY_BKSP  = 4'hB;
  localparam logic [3:0]  KEY_CLR   = 4'hC;
  localparam logic [13:0] MAX_NUM   = 14'd8191;

  // Debounce states
  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } db_state_e;

  // Classification of one complete 4-row scan
  typedef enum logic [1:0] {
    RES_NONE  = 2'd0,
    RES_KEY   = 2'd1,
    RES_MULTI = 2'd2
  } scan_res_e;

  // Matrix position (row*4+col) to key value
  function automatic logic [3:0] key_of_code(input logic [3:0] code);
    case (code)
      4'd0:    key_of_code = 4'h1;
      4'd1:    key_of_code = 4'h2;
      4'd2:    key_of_code = 4'h3;
      4'd3:    key_of_code = 4'hA;
      4'd4:    key_of_code = 4'h4;
      4'd5:    key_of_code = 4'h5;
      4'd6:    key_of_code = 4'h6;
      4'd7:    key_of_code = 4'hB;
      4'd8:    key_of_code = 4'h7;
      4'd9:    key_of_code = 4'h8;
      4'd10:   key_of_code = 4'h9;
      4'd11:   key_of_code = 4'hC;
      4'd12:   key_of_code = 4'hE;
      4'd13:   key_of_code = 4'h0;
      4'd14:   key_of_code = 4'hF;
      4'd15:   key_of_code = 4'hD;
      default: key_of_code = 4'h0;
    endcase
  endfunction

  // One-hot-low row drive pattern for a row index
  function automatic logic [3:0] row_drive(input logic [1:0] idx);
    row_drive = ~(4'b0001 << idx);
  endfunction

  // Number of active-low columns in a sense word
  function automatic logic [2:0] count_low(input logic [3:0] col);
    count_low = {2'b00, ~col[0]} + {2'b00, ~col[1]} + {2'b00, ~col[2]} + {2'b00, ~col[3]};
  endfunction

  // Four BCD digits to binary; 9999 fits in 14 bits
  function automatic logic [13:0] bcd_to_bin(input logic [15:0] bcd);
    bcd_to_bin = ({10'd0, bcd[15:12]} * 14'd1000)
               + ({10'd0, bcd[11:8]}  * 14'd100)
               + ({10'd0, bcd[7:4]}   * 14'd10)
               +  {10'd0, bcd[3:0]};
  endfunction

endpackage

// File: rtl/keypad_number_entry_if.sv
// Keypad lines and entry results bundled for the keypad number entry block.
interface keypad_number_entry_if;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] entry_bcd;
  logic [2:0]  digit_count;
  logic [12:0] num;
  logic        num_valid;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic        err;

  modport master (
    output row_n, entry_bcd, digit_count, num, num_valid, key_strobe, key_code, err,
    input  col_n
  );

  modport slave (
    input  row_n, entry_bcd, digit_count, num, num_valid, key_strobe, key_code, err,
    output col_n
  );
endinterface

// File: rtl/keypad_number_entry_scanner.sv
// Row scanning, column synchronizer, scan classification and debounce FSM.
module keypad_number_entry_scanner #(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] row_n,
  input  logic [3:0] col_n,
  output logic       key_strobe,
  output logic [3:0] key_code
);
  import keypad_number_entry_pkg::*;

  localparam int             DW         = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
  localparam logic [DW-1:0]  DWELL_LAST = DW'(SCAN_TICKS - 1);
  localparam int             CW         = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
  localparam logic [CW-1:0]  CNT_DONE   = CW'(DEBOUNCE_SCANS);

  logic [3:0]    col_meta_r;
  logic [3:0]    col_sync_r;
  logic [1:0]    row_idx_r;
  logic [DW-1:0] dwell_r;
  logic [3:0]    row_n_r;
  logic [1:0]    acc_lows_r;
  logic [3:0]    acc_code_r;
  logic          res_valid_r;
  scan_res_e     res_kind_r;
  logic [3:0]    res_code_r;

  logic          is_sample_s;
  logic [2:0]    sample_cnt_s;
  logic [1:0]    sample_col_s;
  logic [2:0]    lows_sum_s;
  logic [1:0]    lows_next_s;
  logic [3:0]    code_next_s;
  scan_res_e     kind_next_s;

  db_state_e     state_r, state_next_s;
  logic [3:0]    cand_r, cand_next_s;
  logic [CW-1:0] cnt_r, cnt_next_s, cnt_inc_s;
  logic          is_key_s, is_same_s, is_nokey_s;
  logic          strobe_s;
  logic          key_strobe_r;
  logic [3:0]    key_code_r;

  // Fold the current row's sample into the running scan result (low count saturates at 2)
  always_comb begin
    is_sample_s  = (dwell_r == DWELL_LAST);
    sample_cnt_s = count_low(col_sync_r);
    case (~col_sync_r)
      4'b0001: sample_col_s = 2'd0;
      4'b0010: sample_col_s = 2'd1;
      4'b0100: sample_col_s = 2'd2;
      4'b1000: sample_col_s = 2'd3;
      default: sample_col_s = 2'd0;
    endcase
    lows_sum_s  = {1'b0, acc_lows_r} + sample_cnt_s;
    lows_next_s = (lows_sum_s >= 3'd2) ? 2'd2 : lows_sum_s[1:0];
    code_next_s = (sample_cnt_s == 3'd1) ? {row_idx_r, sample_col_s} : acc_code_r;
    case (lows_next_s)
      2'd0:    kind_next_s = RES_NONE;
      2'd1:    kind_next_s = RES_KEY;
      default: kind_next_s = RES_MULTI;
    endcase
  end

  // Synchronize columns, step the row dwell and publish one result per full scan
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_meta_r  <= 4'hF;
      col_sync_r  <= 4'hF;
      row_idx_r   <= 2'd0;
      dwell_r     <= '0;
      row_n_r     <= 4'b1110;
      acc_lows_r  <= 2'd0;
      acc_code_r  <= 4'd0;
      res_valid_r <= 1'b0;
      res_kind_r  <= RES_NONE;
      res_code_r  <= 4'd0;
    end else begin
      col_meta_r  <= col_n;
      col_sync_r  <= col_meta_r;
      res_valid_r <= 1'b0;
      if (is_sample_s) begin
        dwell_r   <= '0;
        row_idx_r <= row_idx_r + 2'd1;
        row_n_r   <= row_drive(row_idx_r + 2'd1);
        if (row_idx_r == 2'd3) begin
          res_valid_r <= 1'b1;
          res_kind_r  <= kind_next_s;
          res_code_r  <= code_next_s;
          acc_lows_r  <= 2'd0;
          acc_code_r  <= 4'd0;
        end else begin
          acc_lows_r  <= lows_next_s;
          acc_code_r  <= code_next_s;
        end
      end else begin
        dwell_r <= dwell_r + DW'(1);
      end
    end
  end

  // Debounce state register with candidate key and scan counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cand_r  <= 4'd0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_next_s;
      cand_r  <= cand_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

  // Debounce next-state: press and release each need DEBOUNCE_SCANS agreeing scans
  always_comb begin
    state_next_s = state_r;
    cand_next_s  = cand_r;
    cnt_next_s   = cnt_r;
    is_key_s     = res_valid_r && (res_kind_r == RES_KEY);
    is_same_s    = is_key_s && (res_code_r == cand_r);
    is_nokey_s   = res_valid_r && (res_kind_r != RES_KEY);
    cnt_inc_s    = cnt_r + CW'(1);
    case (state_r)
      ST_IDLE: begin
        if (is_key_s) begin
          cand_next_s  = res_code_r;
          cnt_next_s   = CNT_ONE;
          state_next_s = (CNT_ONE == CNT_DONE) ? ST_HELD : ST_PRESS_WAIT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_PRESS_WAIT: begin
        if (is_same_s) begin
          cnt_next_s   = cnt_inc_s;
          state_next_s = (cnt_inc_s == CNT_DONE) ? ST_HELD : ST_PRESS_WAIT;
        end else if (is_key_s) begin
          cand_next_s  = res_code_r;
          cnt_next_s   = CNT_ONE;
        end else if (is_nokey_s) begin
          state_next_s = ST_IDLE;
        end else begin
          state_next_s = ST_PRESS_WAIT;
        end
      end
      ST_HELD: begin
        if (res_valid_r && !is_same_s) begin
          cnt_next_s   = CNT_ONE;
          state_next_s = (is_nokey_s && (CNT_ONE == CNT_DONE)) ? ST_IDLE : ST_RELEASE_WAIT;
        end else begin
          state_next_s = ST_HELD;
        end
      end
      ST_RELEASE_WAIT: begin
        if (is_nokey_s) begin
          cnt_next_s   = cnt_inc_s;
          state_next_s = (cnt_inc_s == CNT_DONE) ? ST_IDLE : ST_RELEASE_WAIT;
        end else if (is_key_s) begin
          state_next_s = ST_HELD;
        end else begin
          state_next_s = ST_RELEASE_WAIT;
        end
      end
      default: begin
        state_next_s = ST_IDLE;
        cnt_next_s   = '0;
      end
    endcase
  end

  // Debounce output: a press is accepted on the scan that completes the count
  always_comb begin
    strobe_s = 1'b0;
    if (is_key_s && (state_r == ST_IDLE) && (CNT_ONE == CNT_DONE)) begin
      strobe_s = 1'b1;
    end else if (is_same_s && (state_r == ST_PRESS_WAIT) && (cnt_inc_s == CNT_DONE)) begin
      strobe_s = 1'b1;
    end else begin
      strobe_s = 1'b0;
    end
  end

  // Register the strobe and hold the accepted key value until the next strobe
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_strobe_r <= 1'b0;
      key_code_r   <= 4'd0;
    end else begin
      key_strobe_r <= strobe_s;
      if (strobe_s) begin
        key_code_r <= key_of_code(res_code_r);
      end else begin
        key_code_r <= key_code_r;
      end
    end
  end

  assign row_n      = row_n_r;
  assign key_strobe = key_strobe_r;
  assign key_code   = key_code_r;

endmodule

// File: rtl/keypad_number_entry.sv
// Keypad number entry: digit accumulation, backspace/clear, and Enter commit to binary.
module keypad_number_entry #(
  parameter int SCAN_TICKS     = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  keypad_number_entry_if.master  bus
);
  import keypad_number_entry_pkg::*;

  logic [3:0]  row_n_s;
  logic        key_strobe_s;
  logic [3:0]  key_code_s;

  logic [15:0] entry_bcd_r, entry_bcd_next_s;
  logic [2:0]  digit_count_r, digit_count_next_s;
  logic [12:0] num_r, num_next_s;
  logic        num_valid_r, num_valid_next_s;
  logic        err_r, err_next_s;
  logic [13:0] value_s;

  keypad_number_entry_scanner #(
    .SCAN_TICKS     (SCAN_TICKS),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) u_scanner (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_n      (row_n_s),
    .col_n      (bus.col_n),
    .key_strobe (key_strobe_s),
    .key_code   (key_code_s)
  );

  // Decide the entry update for the key accepted this cycle
  always_comb begin
    entry_bcd_next_s   = entry_bcd_r;
    digit_count_next_s = digit_count_r;
    num_next_s         = num_r;
    num_valid_next_s   = 1'b0;
    err_next_s         = 1'b0;
    value_s            = bcd_to_bin(entry_bcd_r);
    if (key_strobe_s) begin
      case (key_code_s)
        KEY_ENTER: begin
          if (digit_count_r == 3'd0) begin
            err_next_s = 1'b1;
          end else if (value_s <= MAX_NUM) begin
            num_next_s         = value_s[12:0];
            num_valid_next_s   = 1'b1;
            entry_bcd_next_s   = 16'h0000;
            digit_count_next_s = 3'd0;
          end else begin
            err_next_s = 1'b1;
          end
        end
        KEY_BKSP: begin
          if (digit_count_r == 3'd0) begin
            err_next_s = 1'b1;
          end else begin
            entry_bcd_next_s   = {4'h0, entry_bcd_r[15:4]};
            digit_count_next_s = digit_count_r - 3'd1;
          end
        end
        KEY_CLR: begin
          entry_bcd_next_s   = 16'h0000;
          digit_count_next_s = 3'd0;
        end
        default: begin
          // Digits shift in; D, E and F fall through with no effect
          if (key_code_s <= 4'h9) begin
            if (digit_count_r < 3'd4) begin
              entry_bcd_next_s   = {entry_bcd_r[11:0], key_code_s};
              digit_count_next_s = digit_count_r + 3'd1;
            end else begin
              err_next_s = 1'b1;
            end
          end else begin
            err_next_s = 1'b0;
          end
        end
      endcase
    end else begin
      err_next_s = 1'b0;
    end
  end

  // Register entry state and the one-cycle result pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_bcd_r   <= 16'h0000;
      digit_count_r <= 3'd0;
      num_r         <= 13'd0;
      num_valid_r   <= 1'b0;
      err_r         <= 1'b0;
    end else begin
      entry_bcd_r   <= entry_bcd_next_s;
      digit_count_r <= digit_count_next_s;
      num_r         <= num_next_s;
      num_valid_r   <= num_valid_next_s;
      err_r         <= err_next_s;
    end
  end

  assign bus.row_n       = row_n_s;
  assign bus.key_strobe  = key_strobe_s;
  assign bus.key_code    = key_code_s;
  assign bus.entry_bcd   = entry_bcd_r;
  assign bus.digit_count = digit_count_r;
  assign bus.num         = num_r;
  assign bus.num_valid   = num_valid_r;
  assign bus.err         = err_r;

endmodule
